// File: rtl/median3_stream_if.sv
// Valid/ready stream bundle for median3_stream: one sample input stream and one median output
// stream.
interface median3_stream_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Upstream source and downstream sink as seen by the environment driving the block.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/median3_stream.sv
// Streaming median-of-3 filter with sliding-window or block mode and a registered output
// stage that sustains one median per cycle under full throughput.
module median3_stream #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  block_mode,
  output logic [1:0]            fill,
  median3_stream_if.slave       bus
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } fill_e;

  fill_e            state_q;
  logic [WIDTH-1:0] s0_q;
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] med;

  function automatic logic [WIDTH-1:0] median3(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] m;
    if (a > b) begin
      m = (b > c) ? b : ((a > c) ? c : a);
    end else begin
      m = (a > c) ? a : ((b > c) ? c : b);
    end
    return m;
  endfunction

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign fill          = state_q;

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = out_valid_q && bus.out_ready;
  assign med      = median3(s1_q, s0_q, bus.in_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      s0_q        <= '0;
      s1_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // A median loaded below in the same cycle overrides this clear.
      if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
      if (in_xfer) begin
        unique case (state_q)
          StEmpty: begin
            s0_q    <= bus.in_data;
            state_q <= StOne;
          end
          StOne: begin
            s1_q    <= s0_q;
            s0_q    <= bus.in_data;
            state_q <= StTwo;
          end
          StTwo: begin
            out_data_q  <= med;
            out_valid_q <= 1'b1;
            if (block_mode) begin
              state_q <= StEmpty;
            end else begin
              s1_q <= s0_q;
              s0_q <= bus.in_data;
            end
          end
          default: state_q <= StEmpty;
        endcase
      end
    end
  end

endmodule
